pipelined_cla_adder: RTL and testbench



---
 rtl/cla_pkg.sv | 25 ++
 rtl/cla_group4.sv | 31 +++
 rtl/pipelined_cla_adder.sv | 146 ++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants, types and helpers for the pipelined carry-lookahead adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: CLA_GROUP_W (lookahead group width), cla_gp_t ({G, P} pair),
// cla_gp4() (group generate/propagate from 4-bit per-bit g/p).
package cla_pkg;

  localparam int CLA_GROUP_W = 4;

  typedef struct packed {
    logic g;
    logic p;
  } cla_gp_t;

  // Group generate/propagate over one 4-bit group (bit 0 is the LSB).
  function automatic cla_gp_t cla_gp4(input logic [CLA_GROUP_W-1:0] g,
                                      input logic [CLA_GROUP_W-1:0] p);
    cla_gp_t r;
    r.p = &p;
    r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return r;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// One 4-bit carry-lookahead group: internal carries from the group carry-in, then sum.
// Latency: combinational.
// Backpressure: none (pure datapath slice).
//
// Ports: g, p  - per-bit generate/propagate of this group
//        cin   - carry into the group (from the group-level lookahead)
//        sum   - 4-bit group sum
module cla_group4
  import cla_pkg::*;
(
  input  logic [CLA_GROUP_W-1:0] g,
  input  logic [CLA_GROUP_W-1:0] p,
  input  logic                   cin,
  output logic [CLA_GROUP_W-1:0] sum
);

  logic [CLA_GROUP_W-1:0] c;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;

  // The MSB generate only feeds the group carry-out, which the top-level
  // lookahead already forms from the registered group G/P.
  logic unused_g3;
  assign unused_g3 = g[3];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder (4-bit groups + group-level lookahead).
// Latency: 2 cycles from acceptance to out_valid; 1 beat/cycle, 2 beats of storage.
// Backpressure: valid/ready; in_ready = !s1_valid | !s2_valid | out_ready (never looks at in_valid).
//
// Ports: clk, rst_n (async, active-low); in_valid/in_ready, a, b, cin [, sub];
//        out_valid/out_ready, sum, carry (out of MSB), ovf (signed overflow).
// Optional feature macro: CLA_SUB_EN adds the sub port (sub=1 -> a - b, cin ignored).
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int NG = WIDTH / CLA_GROUP_W;

  if ((WIDTH % CLA_GROUP_W) != 0 || WIDTH < CLA_GROUP_W) begin : g_width_chk
    $error("pipelined_cla_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  // Operand conditioning: subtraction is a + ~b + 1.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
`ifdef CLA_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // Handshake
  logic s1_valid, s2_valid, s1_adv, s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s2_adv) s2_valid <= s1_valid;
    end
  end

  // Stage 1: per-bit and per-group generate/propagate
  logic [WIDTH-1:0]       g_nxt, p_nxt;
  cla_gp_t [NG-1:0]       gp_nxt;
  logic [WIDTH-1:0]       s1_g, s1_p;
  cla_gp_t [NG-1:0]       s1_gp;
  logic                   s1_cin;

  assign g_nxt = a & b_eff;
  assign p_nxt = a ^ b_eff;

  always_comb begin
    gp_nxt = '0;
    for (int k = 0; k < NG; k++) begin
      gp_nxt[k] = cla_gp4(g_nxt[k*CLA_GROUP_W +: CLA_GROUP_W],
                          p_nxt[k*CLA_GROUP_W +: CLA_GROUP_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_g   <= '0;
      s1_p   <= '0;
      s1_gp  <= '0;
      s1_cin <= 1'b0;
    end else if (s1_adv && in_valid) begin
      s1_g   <= g_nxt;
      s1_p   <= p_nxt;
      s1_gp  <= gp_nxt;
      s1_cin <= cin_eff;
    end
  end

  // Stage 2: group carries, fully expanded:
  // C_{k+1} = G_k | P_k G_{k-1} | ... | P_k..P_0 cin
  logic [NG:0] gc;
  logic        acc, term;

  always_comb begin
    gc    = '0;
    acc   = 1'b0;
    term  = 1'b0;
    gc[0] = s1_cin;
    for (int k = 0; k < NG; k++) begin
      acc = s1_cin;
      for (int j = 0; j <= k; j++) acc = acc & s1_gp[j].p;
      for (int j = 0; j <= k; j++) begin
        term = s1_gp[j].g;
        for (int m = j + 1; m <= k; m++) term = term & s1_gp[m].p;
        acc = acc | term;
      end
      gc[k+1] = acc;
    end
  end

  logic [WIDTH-1:0] grp_sum;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group4 u_grp (
      .g   (s1_g[k*CLA_GROUP_W +: CLA_GROUP_W]),
      .p   (s1_p[k*CLA_GROUP_W +: CLA_GROUP_W]),
      .cin (gc[k]),
      .sum (grp_sum[k*CLA_GROUP_W +: CLA_GROUP_W])
    );
  end

  // Carry into the MSB is recovered as sum ^ p at that bit.
  logic msb_cin;
  assign msb_cin = grp_sum[WIDTH-1] ^ s1_p[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      sum   <= grp_sum;
      carry <= gc[NG];
      ovf   <= gc[NG] ^ msb_cin;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH = 16).
// Results are modelled as {carry, ovf, sum}; a scoreboard queue is filled on
// every accepted input beat and drained on every output transfer.
module tb_pipelined_cla_adder;

  localparam int W = 16;
`ifdef CLA_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  typedef logic [W+1:0] res_t;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, carry, ovf;
  logic [W-1:0] a, b, sum;

  res_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   ins    = 0;
  int   outs   = 0;
  logic acc_in, acc_out;
  res_t obs;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .ovf       (ovf)
  );

  // Reference: plain wide addition, overflow from operand/result signs.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s);
    logic [W-1:0] ye;
    logic         ce, o;
    logic [W:0]   full;
    ye   = (SUB_EN && s) ? ~y : y;
    ce   = (SUB_EN && s) ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, ce};
    o    = (x[W-1] == ye[W-1]) && (full[W-1] != x[W-1]);
    return {full[W], o, full[W-1:0]};
  endfunction

  task automatic chk(input string tag, input res_t o, input res_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Called just after a falling edge with inputs already driven: samples the
  // handshake, runs the scoreboard, and returns after the next falling edge.
  task automatic cycle();
    #1;
    acc_in  = in_valid && in_ready;
    acc_out = out_valid && out_ready;
    obs     = {carry, ovf, sum};
    if (acc_out) begin
      outs++;
      if (q.size() == 0) chk("sb_unexpected_beat", res_t'(acc_out), '0);
      else               chk("sb_data", obs, q.pop_front());
    end
    if (acc_in) begin
      ins++;
      q.push_back(model(a, b, cin, sub));
    end
    @(negedge clk);
  endtask

  // One isolated beat with out_ready high: checks latency and the directed value.
  task automatic send_one(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic s, input res_t exp);
    out_ready = 1'b1;
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    cycle();
    chk({tag, "_accept"}, res_t'(acc_in), 1);
    in_valid = 1'b0;
    #1 chk({tag, "_lat_s1"}, res_t'(out_valid), 0);
    cycle();
    #1 chk({tag, "_lat_s2"}, res_t'(out_valid), 1);
    chk(tag, {carry, ovf, sum}, exp);
    cycle();
  endtask

  logic [W-1:0] bp_a [4];
  logic [W-1:0] bp_b [4];
  int           k;

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_outputs", {carry, ovf, sum}, '0);
    chk("rst_out_valid", res_t'(out_valid), 0);
    chk("rst_in_ready", res_t'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_out_valid", res_t'(out_valid), 0);
    chk("rel_sum", res_t'(sum), 0);
    chk("rel_in_ready", res_t'(in_ready), 1);
    @(negedge clk);

    // Directed adds
    send_one("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 18'h05555);
    send_one("ripple_ffff_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 18'h20000);
    send_one("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h18000);
    send_one("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 18'h30000);
`ifdef CLA_SUB_EN
    send_one("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 18'h0FFFE);
    send_one("sub_7_5_cin_ign", 16'h0007, 16'h0005, 1'b0, 1'b1, 18'h20002);
`endif

    // Backpressure: 4 beats offered with out_ready low
    bp_a[0] = 16'h1111; bp_b[0] = 16'h0101;
    bp_a[1] = 16'h2222; bp_b[1] = 16'hF0F0;
    bp_a[2] = 16'h8001; bp_b[2] = 16'h8001;
    bp_a[3] = 16'hABCD; bp_b[3] = 16'h1234;
    out_ready = 1'b0; cin = 1'b0; sub = 1'b0; k = 0;
    for (int s = 0; s < 4; s++) begin
      a = bp_a[k]; b = bp_b[k]; in_valid = 1'b1;
      cycle();
      if (acc_in) k++;
    end
    #1;
    chk("bp_accepted", res_t'(k), 2);
    chk("bp_in_ready_low", res_t'(in_ready), 0);
    chk("bp_out_valid", res_t'(out_valid), 1);
    chk("bp_hold_0", {carry, ovf, sum}, model(bp_a[0], bp_b[0], 1'b0, 1'b0));
    cycle();
    #1 chk("bp_hold_1", {carry, ovf, sum}, model(bp_a[0], bp_b[0], 1'b0, 1'b0));
    out_ready = 1'b1;
    for (int s = 0; s < 12 && !(k == 4 && q.size() == 0); s++) begin
      if (k < 4) begin a = bp_a[k]; b = bp_b[k]; in_valid = 1'b1; end
      else in_valid = 1'b0;
      cycle();
      if (acc_in) k++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", res_t'(k), 4);
    chk("bp_drained", res_t'(q.size()), 0);

    // Full throughput: back-to-back beats with out_ready high
    out_ready = 1'b1; k = 0;
    for (int s = 0; s < 16; s++) begin
      a = 16'(s * 16'h1111); b = 16'(16'hFFFF - s * 16'h0F0F); cin = s[0]; in_valid = 1'b1;
      cycle();
      if (acc_in) k++;
    end
    in_valid = 1'b0;
    chk("thru_accepted", res_t'(k), 16);
    for (int s = 0; s < 6 && q.size() != 0; s++) cycle();
    chk("thru_drained", res_t'(q.size()), 0);

    // Reset with both stages full
    out_ready = 1'b0; in_valid = 1'b1; a = 16'h0F0F; b = 16'h00F1; cin = 1'b0;
    cycle();
    a = 16'h3333; b = 16'h4444;
    cycle();
    in_valid = 1'b0;
    #1 chk("mid_full", res_t'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", res_t'(out_valid), 0);
    chk("mid_rst_outputs", {carry, ovf, sum}, '0);
    chk("mid_rst_in_ready", res_t'(in_ready), 1);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1 chk("post_rst_no_stale", res_t'(out_valid), 0);
      cycle();
    end

    // Random traffic with random backpressure
    ins = 0; outs = 0;
    for (int s = 0; s < 3000; s++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int s = 0; s < 10 && q.size() != 0; s++) cycle();
    chk("rand_drained", res_t'(q.size()), 0);
    chk("rand_beat_count", res_t'(outs), res_t'(ins));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
